// File: rtl/spike_synapse_pkg.sv
// Shared types and saturating helpers for the CPG synapse.
// Arithmetic helpers work on 32-bit values, so callers must keep W at 31 or below.
package cpg_pkg;

   localparam int unsigned SYN_W = 8;

   typedef enum logic {
      IDLE   = 1'b0,
      REFRAC = 1'b1
   } syn_state_t;

   function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                           input int unsigned max_v);
      int unsigned s;
      s = a + b;
      return (s > max_v) ? max_v : s;
   endfunction

   function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
      return (a >= b) ? (a - b) : 0;
   endfunction

endpackage

// File: rtl/spike_synapse_if.sv
// Synapse signal bundle: the presynaptic side drives it as master,
// and the synapse consumes it as slave.
interface spike_synapse_if
   import cpg_pkg::*;
#(
   parameter int unsigned W = SYN_W
);
   logic         spike_in;
   logic [W-1:0] weight;
   logic [W-1:0] bias;
   logic [2:0]   decay_shift;
   logic [W-1:0] i_ext;
   logic [W-1:0] syn_current;
   logic [7:0]   spike_cnt;

   modport master (
      output spike_in, weight, bias, decay_shift,
      input  i_ext, syn_current, spike_cnt
   );

   modport slave (
      input  spike_in, weight, bias, decay_shift,
      output i_ext, syn_current, spike_cnt
   );
endinterface

// File: rtl/spike_synapse_prescaler.sv
// Free-running decay prescaler: counts 0..DECAY_DIV-1 and emits a one-cycle
// tick while the count sits at DECAY_DIV-1.
module syn_prescaler
   import cpg_pkg::*;
#(
   parameter int unsigned DECAY_DIV = 16
) (
   input  logic clk,
   input  logic reset,
   output logic o_tick
);
   localparam int unsigned     CW   = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
   localparam logic [CW-1:0]   LAST = CW'(DECAY_DIV - 1);

   logic [CW-1:0] r_cnt;
   logic          w_wrap;

   assign w_wrap = (r_cnt == LAST);
   assign o_tick = w_wrap;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (w_wrap) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/spike_synapse.sv
// Spike-driven synapse: weight jump per accepted spike, tick-driven exponential decay,
// refractory window, biased drive to the next neuron. SYN_INHIB_EN selects inhibitory drive.
module spike_synapse
   import cpg_pkg::*;
#(
   parameter int unsigned W          = SYN_W,
   parameter int unsigned DECAY_DIV  = 16,
   parameter int unsigned REFRAC_CYC = 4
) (
   input  logic            clk,
   input  logic            reset,
   spike_synapse_if.slave  bus
);
   localparam int unsigned RW   = $clog2(REFRAC_CYC + 1);
   localparam int unsigned GMAX = (2 ** W) - 1;

   syn_state_t   r_state, w_state_nxt;
   logic [RW-1:0] r_rcnt, w_rcnt_nxt;
   logic          r_spike_prev;
   logic [W-1:0]  r_g, w_g_nxt, w_gd, w_dec;
   logic [W-1:0]  r_i_ext, w_iext_nxt;
   logic [7:0]    r_spike_cnt;
   logic          w_edge, w_accept, w_tick;

   syn_prescaler #(
      .DECAY_DIV (DECAY_DIV)
   ) u_prescaler (
      .clk    (clk),
      .reset  (reset),
      .o_tick (w_tick)
   );

   assign w_edge = bus.spike_in & ~r_spike_prev;

   always_comb begin
      w_state_nxt = r_state;
      w_rcnt_nxt  = r_rcnt;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_edge) begin
               w_accept    = 1'b1;
               w_rcnt_nxt  = RW'(REFRAC_CYC - 1);
               w_state_nxt = REFRAC;
            end
         end
         REFRAC: begin
            if (r_rcnt == '0) begin
               w_state_nxt = IDLE;
            end else begin
               w_rcnt_nxt = r_rcnt - 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Decay applies before the weight add so a tick and a spike in one cycle fold into one update.
   always_comb begin
      w_dec = r_g >> bus.decay_shift;
      if ((r_g != '0) && (w_dec == '0)) begin
         w_dec = W'(1);
      end
      w_gd    = w_tick ? (r_g - w_dec) : r_g;
      w_g_nxt = w_accept ? W'(sat_add(32'(w_gd), 32'(bus.weight), GMAX)) : w_gd;
`ifdef SYN_INHIB_EN
      w_iext_nxt = W'(sat_sub(32'(bus.bias), 32'(r_g)));
`else
      w_iext_nxt = W'(sat_add(32'(bus.bias), 32'(r_g), GMAX));
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_rcnt       <= '0;
         r_spike_prev <= 1'b0;
         r_g          <= '0;
         r_i_ext      <= '0;
         r_spike_cnt  <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_rcnt       <= w_rcnt_nxt;
         r_spike_prev <= bus.spike_in;
         r_g          <= w_g_nxt;
         r_i_ext      <= w_iext_nxt;
         if (w_accept) begin
            r_spike_cnt <= r_spike_cnt + 8'd1;
         end
      end
   end

   assign bus.i_ext       = r_i_ext;
   assign bus.syn_current = r_g;
   assign bus.spike_cnt   = r_spike_cnt;
endmodule

// File: tb/tb_spike_synapse.sv
// Self-checking bench for spike_synapse: directed table, corner sequences, randomized run.
module tb_spike_synapse;
   localparam int DIV    = 16;
   localparam int REFRAC = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   spike_synapse_if #(.W(8)) bus ();

   spike_synapse #(
      .W          (8),
      .DECAY_DIV  (DIV),
      .REFRAC_CYC (REFRAC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: cycle index since reset, time of last accepted spike.
   int m_g, m_iext, m_cnt, m_prev, m_k, m_last;

   typedef struct {
      bit spike;
      int weight;
      int bias;
      int shift;
      int exp_g;
      int exp_cnt;
      int exp_iext_exc;
      int exp_iext_inh;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_g = 0; m_iext = 0; m_cnt = 0; m_prev = 0; m_k = 0; m_last = -1000;
   endtask

   function automatic int drive_of(input int bias, input int g);
`ifdef SYN_INHIB_EN
      return (g >= bias) ? 0 : bias - g;
`else
      return (bias + g > 255) ? 255 : bias + g;
`endif
   endfunction

   task automatic step();
      int d, gd, g_new, iext_new;
      bit tick, acc;
      tick = ((m_k % DIV) == DIV - 1);
      d = m_g >> int'(bus.decay_shift);
      if (m_g != 0 && d == 0) d = 1;
      gd = tick ? m_g - d : m_g;
      acc = bus.spike_in && (m_prev == 0) && (m_k >= m_last + REFRAC + 1);
      g_new = acc ? ((gd + int'(bus.weight) > 255) ? 255 : gd + int'(bus.weight)) : gd;
      iext_new = drive_of(int'(bus.bias), m_g);
      m_prev = int'(bus.spike_in);
      @(posedge clk);
      #1;
      if (acc) begin
         m_cnt = (m_cnt + 1) % 256;
         m_last = m_k;
      end
      m_g = g_new;
      m_iext = iext_new;
      m_k++;
      chk("model_g", int'(bus.syn_current), m_g);
      chk("model_i_ext", int'(bus.i_ext), m_iext);
      chk("model_spike_cnt", int'(bus.spike_cnt), m_cnt);
   endtask

   task automatic do_reset();
      bus.spike_in = 1'b0;
      #1 reset = 1'b1;
      model_reset();
      #1;
      chk("reset_g", int'(bus.syn_current), 0);
      chk("reset_i_ext", int'(bus.i_ext), 0);
      chk("reset_spike_cnt", int'(bus.spike_cnt), 0);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      vec_t tbl[17];
      int   dk[5];
      int   dg[5];
      int   exp_i;

      tbl = '{
         '{0, 40, 10, 2,  0, 0, 10, 10},
         '{1, 40, 10, 2, 40, 1, 10, 10},
         '{0, 40, 10, 2, 40, 1, 50,  0},
         '{1, 40, 10, 2, 40, 1, 50,  0},
         '{0, 40, 10, 2, 40, 1, 50,  0},
         '{0, 40, 10, 2, 40, 1, 50,  0},
         '{1, 40, 10, 2, 80, 2, 50,  0},
         '{0, 40, 10, 2, 80, 2, 90,  0},
         '{0, 40, 10, 2, 80, 2, 90,  0},
         '{0, 40, 10, 2, 80, 2, 90,  0},
         '{0, 40, 10, 2, 80, 2, 90,  0},
         '{0, 40, 10, 2, 80, 2, 90,  0},
         '{0, 40, 10, 2, 80, 2, 90,  0},
         '{0, 40, 10, 2, 80, 2, 90,  0},
         '{0, 40, 10, 2, 80, 2, 90,  0},
         '{0, 40, 10, 2, 60, 2, 90,  0},
         '{0, 40, 10, 2, 60, 2, 70,  0}
      };

      bus.spike_in    = 1'b0;
      bus.weight      = 8'd40;
      bus.bias        = 8'd10;
      bus.decay_shift = 3'd2;
      model_reset();
      #3;

      // Directed table: reset release, refractory window, decay tick at cycle 15.
      do_reset();
      for (int i = 0; i < 17; i++) begin
         bus.spike_in    = tbl[i].spike;
         bus.weight      = 8'(tbl[i].weight);
         bus.bias        = 8'(tbl[i].bias);
         bus.decay_shift = 3'(tbl[i].shift);
         step();
         chk($sformatf("tbl%0d_g", i), int'(bus.syn_current), tbl[i].exp_g);
         chk($sformatf("tbl%0d_cnt", i), int'(bus.spike_cnt), tbl[i].exp_cnt);
`ifdef SYN_INHIB_EN
         chk($sformatf("tbl%0d_i_ext", i), int'(bus.i_ext), tbl[i].exp_iext_inh);
`else
         chk($sformatf("tbl%0d_i_ext", i), int'(bus.i_ext), tbl[i].exp_iext_exc);
`endif
      end

      // Saturation: weight 200, spikes 10 cycles apart.
      do_reset();
      bus.weight = 8'd200; bus.bias = 8'd10; bus.decay_shift = 3'd2;
      for (int k = 0; k <= 11; k++) begin
         bus.spike_in = (k == 0 || k == 10);
         step();
         if (k == 0) chk("sat_first_g", int'(bus.syn_current), 200);
         if (k == 10) chk("sat_second_g", int'(bus.syn_current), 255);
      end
      exp_i = drive_of(10, 255);
      chk("sat_i_ext", int'(bus.i_ext), exp_i);

      // Decay floor: g=3 with shift 2 steps down by one per tick and stays at zero.
      do_reset();
      bus.weight = 8'd3; bus.decay_shift = 3'd2;
      dk = '{14, 15, 31, 47, 63};
      dg = '{3, 2, 1, 0, 0};
      for (int k = 0; k <= 63; k++) begin
         bus.spike_in = (k == 0);
         step();
         for (int j = 0; j < 5; j++) begin
            if (dk[j] == k) chk($sformatf("decay_k%0d_g", k), int'(bus.syn_current), dg[j]);
         end
      end

      // Async reset mid-refractory, then immediate acceptance from IDLE.
      do_reset();
      bus.weight = 8'd40; bus.bias = 8'd10;
      bus.spike_in = 1'b1; step();
      bus.spike_in = 1'b0; step();
      chk("pre_reset_g", int'(bus.syn_current), 40);
      do_reset();
      bus.weight = 8'd4;
      bus.spike_in = 1'b1; step();
      chk("post_reset_accept_cnt", int'(bus.spike_cnt), 1);
      chk("post_reset_g", int'(bus.syn_current), 4);
      bus.spike_in = 1'b0; step();
`ifdef SYN_INHIB_EN
      chk("g4_i_ext", int'(bus.i_ext), 6);
`else
      chk("g4_i_ext", int'(bus.i_ext), 14);
`endif

      // Randomized run against the model, with occasional resets.
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         if (c % 50 == 0) begin
            bus.weight      = 8'($urandom_range(0, 255));
            bus.bias        = 8'($urandom_range(0, 255));
            bus.decay_shift = 3'($urandom_range(0, 7));
         end
         bus.spike_in = ($urandom_range(0, 99) < 35);
         step();
         if (c % 997 == 996) do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
